// File: rtl/cmp32_share_ctrl.sv
// cmp32_share_ctrl
// Round-robin controller that time-shares one external combinational unsigned
// less-than comparator among NREQ requesters. It accepts one request at a time,
// drives the comparator operands from registers, maps the less-than result onto
// the requested relation, and returns it on a per-requester response channel.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready per-requester request handshake (ready is one-hot or zero)
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op              packed 2-bit opcodes: 0=LT 1=GE 2=GT 3=LE
//   rsp_valid/rsp_ready per-requester response handshake (valid is one-hot or zero)
//   rsp_res             relational result for the flagged requester
//   cmp_a, cmp_b        registered operands to the shared comparator
//   cmp_lt              comparator result (cmp_a < cmp_b, unsigned)
//   busy                high while an operation is in flight
//   done_cnt            wrapping count of accepted responses
module cmp32_share_ctrl #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic                  rsp_res,
  output logic [WIDTH-1:0]      cmp_a,
  output logic [WIDTH-1:0]      cmp_b,
  input  logic                  cmp_lt,
  output logic                  busy,
  output logic [15:0]           done_cnt
);

  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW1 = GW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [GW-1:0]       ptr_r;
  logic [GW-1:0]       gnt_r;
  logic [1:0]          op_r;
  logic                res_r;
  logic [WIDTH-1:0]    cmp_a_r, cmp_b_r;
  logic [NREQ-1:0]     rsp_valid_r;
  logic [15:0]         done_cnt_r;

  logic [2*NREQ-1:0]   dbl_s;
  logic [2*NREQ-1:0]   sh_s;
  logic [NREQ-1:0]     rot_s;
  logic                gnt_found_s;
  logic [GW-1:0]       gnt_idx_s;
  logic [WIDTH-1:0]    sel_a_s, sel_b_s;
  logic [1:0]          sel_op_s;
  logic                rsp_acc_s;
  logic [NREQ-1:0]     req_ready_s;

  // (p + k) mod NREQ without a divider; p < NREQ and k < NREQ keep one subtract enough
  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] p, input int k);
    logic [GW1-1:0] s;
    s = {1'b0, p} + GW1'(k);
    if (s >= GW1'(NREQ)) begin
      s = s - GW1'(NREQ);
    end else begin
      s = s;
    end
    return s[GW-1:0];
  endfunction

  // Rotate the valid vector so bit 0 is the requester at ptr; scanning upward is then round-robin
  assign dbl_s = {req_valid, req_valid};
  assign sh_s  = dbl_s >> ptr_r;
  assign rot_s = sh_s[NREQ-1:0];

  // First valid requester at or after ptr
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found_s && rot_s[k]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = wrap_idx(ptr_r, k);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Operand and opcode mux for the candidate grant
  always_comb begin
    sel_a_s  = '0;
    sel_b_s  = '0;
    sel_op_s = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx_s == GW'(k)) begin
        sel_a_s  = req_a[k*WIDTH +: WIDTH];
        sel_b_s  = req_b[k*WIDTH +: WIDTH];
        sel_op_s = req_op[k*2 +: 2];
      end else begin
        sel_op_s = sel_op_s;
      end
    end
  end

  // Ready is driven only in IDLE and only from state, ptr and req_valid
  always_comb begin
    req_ready_s = '0;
    if (state_r == IDLE && gnt_found_s) begin
      req_ready_s = NREQ'(1) << gnt_idx_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // rsp_valid_r is one-hot on the granted requester, so this ignores other rsp_ready bits
  assign rsp_acc_s = |(rsp_valid_r & rsp_ready);

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_found_s) begin
          state_s = CMP;
        end else begin
          state_s = IDLE;
        end
      end
      CMP:  state_s = RESP;
      RESP: begin
        if (rsp_acc_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: capture at handshake, evaluate in CMP, retire in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= '0;
      gnt_r       <= '0;
      op_r        <= 2'd0;
      res_r       <= 1'b0;
      cmp_a_r     <= '0;
      cmp_b_r     <= '0;
      rsp_valid_r <= '0;
      done_cnt_r  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_found_s) begin
            gnt_r <= gnt_idx_s;
            op_r  <= sel_op_s;
            // GT and LE (op[1]=1) are a<b with operands swapped
            if (sel_op_s[1]) begin
              cmp_a_r <= sel_b_s;
              cmp_b_r <= sel_a_s;
            end else begin
              cmp_a_r <= sel_a_s;
              cmp_b_r <= sel_b_s;
            end
          end
        end
        CMP: begin
          // GE and LE (op[0]=1) are the complement of the less-than result
          res_r       <= cmp_lt ^ op_r[0];
          rsp_valid_r <= NREQ'(1) << gnt_r;
        end
        RESP: begin
          if (rsp_acc_s) begin
            rsp_valid_r <= '0;
            done_cnt_r  <= done_cnt_r + 16'd1;
            if (gnt_r == GW'(NREQ - 1)) begin
              ptr_r <= '0;
            end else begin
              ptr_r <= gnt_r + GW'(1);
            end
          end
        end
        default: begin
          rsp_valid_r <= '0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_res   = res_r;
  assign cmp_a     = cmp_a_r;
  assign cmp_b     = cmp_b_r;
  assign busy      = (state_r != IDLE);
  assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_cmp32_share_ctrl.sv
// Scoreboard bench for cmp32_share_ctrl: the stimulus side pushes the
// hand-computed response for each accepted request, and a negedge monitor pops
// and compares whenever a response handshake is presented.
module tb_cmp32_share_ctrl;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ*2-1:0]     req_op = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready = '1;
  logic                  rsp_res;
  logic [WIDTH-1:0]      cmp_a, cmp_b;
  logic                  cmp_lt;
  logic                  busy;
  logic [15:0]           done_cnt;

  cmp32_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_lt(cmp_lt),
    .busy(busy), .done_cnt(done_cnt)
  );

  // external shared comparator
  assign cmp_lt = (cmp_a < cmp_b);

  always #5 clk = ~clk;

  typedef struct {
    int   idx;
    logic res;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_idx_q[$];
  int   gnt_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  localparam logic [1:0] OP_LT = 2'd0;
  localparam logic [1:0] OP_GE = 2'd1;
  localparam logic [1:0] OP_GT = 2'd2;
  localparam logic [1:0] OP_LE = 2'd3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: grant log, ready exclusivity, response scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready_onehot0", 64'($countones(req_ready) <= 1), 64'd1);
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          gnt_idx_q.push_back(k);
          gnt_cyc_q.push_back(cyc);
        end
      end
      if (|(rsp_valid & rsp_ready)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'(1 << e.idx));
          check("rsp_res", 64'(rsp_res), 64'(e.res));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*2 +: 2]        = op;
  endtask

  // drive mask; once requester i is granted push its expected result; returns #1 into the CMP cycle
  task automatic issue(input logic [NREQ-1:0] mask, input int i, input logic res);
    bit got = 1'b0;
    req_valid = mask;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        check("req_ready_grant", 64'(req_ready), 64'(1 << i));
        exp_q.push_back('{idx: i, res: res});
        got = 1'b1;
        break;
      end
    end
    if (!got) check("grant_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  // wait for every expected response, then check the FSM is back in IDLE
  task automatic drain(input logic [15:0] done_exp);
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    check("busy_idle", 64'(busy), 64'd0);
    check("done_cnt", 64'(done_cnt), 64'(done_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_res"},   64'(rsp_res),   64'd0);
    check({tag, "_cmp_a"},     64'(cmp_a),     64'd0);
    check({tag, "_cmp_b"},     64'(cmp_b),     64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done_cnt"},  64'(done_cnt),  64'd0);
  endtask

  logic [31:0] sw_a   [4] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 32'h8000_0000};
  logic [31:0] sw_b   [4] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0001, 32'h8000_0000};
  logic [1:0]  sw_op  [4] = '{OP_GT, OP_LE, OP_GE, OP_LT};
  logic        sw_res [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  int          arb_idx [6] = '{0, 1, 2, 3, 0, 1};
  logic        arb_res [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // reset state
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic LT on req0
    set_req(0, 32'd5, 32'd7, OP_LT);
    issue(4'b0001, 0, 1'b1);
    check("basic_cmp_a", 64'(cmp_a), 64'd5);
    check("basic_cmp_b", 64'(cmp_b), 64'd7);
    check("basic_rsp_valid_t1", 64'(rsp_valid), 64'd0);
    check("basic_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("basic_rsp_valid_t2", 64'(rsp_valid), 64'b0001);
    check("basic_rsp_res_t2", 64'(rsp_res), 64'd1);
    drain(16'd1);

    // opcode sweep on req2
    for (int s = 0; s < 4; s++) begin
      set_req(2, sw_a[s], sw_b[s], sw_op[s]);
      issue(4'b0100, 2, sw_res[s]);
      if (s == 0) begin
        check("gt_swap_cmp_a", 64'(cmp_a), 64'h0);
        check("gt_swap_cmp_b", 64'(cmp_b), 64'hFFFF_FFFF);
      end
      drain(16'(s + 2));
    end

    // arbitration: all requesters valid from reset release
    rst_n = 1'b0;
    gnt_idx_q.delete();
    gnt_cyc_q.delete();
    set_req(0, 32'd0, 32'd2, OP_LT);
    set_req(1, 32'd1, 32'd2, OP_GE);
    set_req(2, 32'd2, 32'd2, OP_GT);
    set_req(3, 32'd3, 32'd2, OP_LE);
    for (int k = 0; k < 6; k++) exp_q.push_back('{idx: arb_idx[k], res: arb_res[k]});
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (gnt_idx_q.size() >= 6) break;
      @(posedge clk); #1;
    end
    req_valid = '0;
    check("arb_grant_count", 64'(gnt_idx_q.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < gnt_idx_q.size()) begin
        check("arb_order", 64'(gnt_idx_q[k]), 64'(arb_idx[k]));
        if (k > 0) check("arb_spacing", 64'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), 64'd3);
      end
    end
    drain(16'd6);

    // backpressure on req1 (ptr is 2 here, req1 is the only one valid)
    set_req(1, 32'd10, 32'd3, OP_GT);
    rsp_ready = 4'b1101;
    issue(4'b0010, 1, 1'b1);
    @(posedge clk); #1;
    set_req(0, 32'd1, 32'd1, OP_LE);
    req_valid = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      check("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
      check("bp_rsp_res", 64'(rsp_res), 64'd1);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = 4'b1111;
    @(posedge clk); #1;
    check("bp_release_idle", 64'(busy), 64'd0);
    check("bp_done_cnt", 64'(done_cnt), 64'd7);
    // ptr=2 with req2 idle: the scan wraps past 3 before 0 and 1
    set_req(3, 32'd3, 32'd2, OP_LE);
    issue(4'b1011, 3, 1'b0);
    drain(16'd8);

    // reset during CMP
    set_req(1, 32'h55, 32'hAA, OP_LT);
    issue(4'b0010, 1, 1'b1);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    set_req(1, 32'd9, 32'd9, OP_GE);
    set_req(2, 32'd0, 32'd0, OP_LT);
    issue(4'b0110, 1, 1'b1);
    drain(16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute time limit
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
